ddr3_sample_streamer: RTL
=========================

// Module: ddr3_sample_streamer
// PURPOSE
//  Consumer stage on the MIG user (app) interface. Issues sequential read commands over a clip stored in DDR3.
//  Buffers the returned 256-bit words in a small credit-controlled FIFO.
//  Unpacks each word into 16-bit PCM samples, one per sample_tick, for the sound output path.
//  Runs entirely in the MIG ui_clk domain.
// PARAMETERS
//  ADDR_W      29    app_addr width
//  DATA_W      256   app_rd_data width
//  SAMPLE_W    16    PCM sample width; DATA_W/SAMPLE_W = 16 lanes per word
//  BASE_ADDR   0     app_addr of first clip word
//  NUM_WORDS   1024  clip length in 256-bit words (>=1)
//  ADDR_STEP   8     app_addr increment per word
//  FIFO_DEPTH  4     read-data buffer depth in words (power of 2)
// PORTS
//  ui_clk              in   1        MIG user clock; all logic on rising edge
//  sys_rst             in   1        async reset, active low
//  init_calib_complete in   1        MIG calibration done
//  start               in   1        1-cycle pulse: begin playback
//  loop                in   1        1: wrap to BASE_ADDR after last word
//  app_addr            out  ADDR_W   read address to MIG
//  app_cmd             out  3        constant 3'b001 (read)
//  app_en              out  1        command valid
//  app_rdy             in   1        MIG accepts command when app_en&&app_rdy
//  app_rd_data         in   DATA_W   returned read word
//  app_rd_data_valid   in   1        app_rd_data valid, in issue order
//  sample_tick         in   1        1-cycle pulse at audio sample rate
//  sample              out  SAMPLE_W current PCM sample (signed)
//  sample_valid        out  1        1-cycle pulse: sample updated
//  busy                out  1        playback in progress
//  underrun_cnt        out  16       ticks with no data while busy, saturating
// BEHAVIOUR
//  Reset (sys_rst=0, async):
//   - app_en=0, app_addr=BASE_ADDR, sample=0, sample_valid=0, busy=0, underrun_cnt=0.
//   - FIFO empty, counters 0, state IDLE.
//  FSM states: IDLE, REQ, DRAIN.
//  IDLE -> REQ on start && init_calib_complete.
//   - Loads app_addr=BASE_ADDR; zeroes word and outstanding counters and underrun_cnt.
//   - busy=1 from the next cycle.
//   - start is ignored outside IDLE or while init_calib_complete=0.
//  REQ:
//   - Credit check: app_en=1 only if outstanding+fifo_count+pending_en < FIFO_DEPTH.
//   - Once raised, app_en and app_addr hold stable until app_rdy=1.
//   - On accept: app_addr+=ADDR_STEP (wrapping at 2^ADDR_W), outstanding++, issued++.
//   - When the accepted word is issued==NUM_WORDS-1:
//       loop=1 -> app_addr=BASE_ADDR, issued=0, stay in REQ;
//       loop=0 -> go to DRAIN.
//   - app_en drops the cycle after the final accept.
//  DRAIN -> IDLE when outstanding==0, FIFO empty, and all 16 lanes of the unpacker consumed; busy=0 in IDLE.
//  FIFO:
//   - Write on app_rd_data_valid; outstanding-- on the same cycle.
//   - Simultaneous push and pop is legal and keeps fifo_count unchanged.
//   - Credits guarantee no overflow; a push when full is a design error (assertion).
//  Unpacker: holds one word plus lane index 0..15; lane 0 = bits[15:0], issued first.
//   - On sample_tick at cycle t, if a lane is available: sample<=lane[idx], sample_valid=1 at t+1, idx++.
//   - After lane 15, the next word is popped from the FIFO; if the FIFO is non-empty a reload
//     costs no extra cycle, so the next tick is still served.
//   - On sample_tick with no lane available while busy: sample<=0, sample_valid=1,
//     underrun_cnt++ (saturates at 16'hFFFF).
//   - sample_tick while !busy: sample<=0, sample_valid=1, no count.
//   - sample_tick and FIFO push in the same cycle: the push is not visible to that tick.
//  app_cmd is tied to 3'b001.
// TESTING
//  T1 NUM_WORDS=2, loop=0, MIG model app_rdy=1, 5-cycle read latency, word k lanes = 16*k+lane:
//     start -> exactly 2 accepts at addr 0,8; samples 0..31 in order;
//     busy falls after the 32nd sample; underrun_cnt=0.
//  T2 app_rdy held 0 for 10 cycles mid-REQ -> app_en stays 1 and app_addr unchanged the whole time;
//     no duplicate or skipped addresses.
//  T3 read latency 40 cycles, FIFO_DEPTH=4 -> never more than 4 outstanding+buffered;
//     FIFO never overflows.
//  T4 sample_tick every cycle with slow MIG -> sample=0 on starved ticks;
//     underrun_cnt equals the starved tick count.
//  T5 loop=1, NUM_WORDS=3 -> addresses 0,8,16,0,8,... ; busy stays 1; continuous samples with no gaps.
//  T6 sys_rst asserted mid-REQ with 2 reads outstanding -> all outputs at reset values immediately;
//     a new start replays from BASE_ADDR.

Source files
------------

// File: rtl/ddr3_sample_streamer.sv
// Streams a DDR3-resident PCM clip over the MIG app interface into a credit-limited word FIFO
// and unpacks each 256-bit word into signed samples, one per sample_tick.
module ddr3_sample_streamer #(
    parameter int                ADDR_W     = 29,
    parameter int                DATA_W     = 256,
    parameter int                SAMPLE_W   = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                NUM_WORDS  = 1024,
    parameter int                ADDR_STEP  = 8,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                       ui_clk,
    input  logic                       sys_rst,
    input  logic                       init_calib_complete,
    input  logic                       start,
    input  logic                       loop,
    output logic [ADDR_W-1:0]          app_addr,
    output logic [2:0]                 app_cmd,
    output logic                       app_en,
    input  logic                       app_rdy,
    input  logic [DATA_W-1:0]          app_rd_data,
    input  logic                       app_rd_data_valid,
    input  logic                       sample_tick,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid,
    output logic                       busy,
    output logic [15:0]                underrun_cnt
);
    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ISS_W  = $clog2(NUM_WORDS) + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [ISS_W-1:0]  LAST_WORD = ISS_W'(NUM_WORDS - 1);
    localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    function automatic logic signed [SAMPLE_W-1:0] lane_sel(input logic [DATA_W-1:0] word,
                                                            input logic [LANE_W-1:0] idx);
        return $signed(word[int'(idx)*SAMPLE_W +: SAMPLE_W]);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t                      state_q, state_d;
    logic                        en_q, en_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [ISS_W-1:0]            issued_q, issued_d;
    logic [CNT_W-1:0]            outst_q, outst_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]           mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]           word_q, word_d;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic                        wvld_q, wvld_d;
    logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
    logic                        sval_q, sval_d;
    logic [15:0]                 under_q, under_d;

    logic                        accept, pop, avail, busy_q;
    logic [DATA_W-1:0]           cur_word;
    logic [LANE_W-1:0]           cur_lane;
    logic [CNT_W:0]              credit_sum;

    assign accept = en_q && app_rdy;
    assign busy_q = (state_q != IDLE);
    assign avail  = wvld_q || (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        word_d     = word_q;
        lane_d     = lane_q;
        wvld_d     = wvld_q;
        sample_d   = sample_q;
        sval_d     = 1'b0;
        under_d    = under_q;
        pop        = 1'b0;
        cur_word   = wvld_q ? word_q : mem_q[rd_ptr_q];
        cur_lane   = wvld_q ? lane_q : '0;

        // An empty unpacker serves lane 0 straight from the FIFO head, so word reloads never cost a tick.
        if (sample_tick) begin
            sval_d   = 1'b1;
            sample_d = '0;
            if (busy_q && avail) begin
                sample_d = lane_sel(cur_word, cur_lane);
                if (!wvld_q) begin
                    pop    = 1'b1;
                    word_d = mem_q[rd_ptr_q];
                    lane_d = LANE_W'(1);
                    wvld_d = 1'b1;
                end else if (lane_q == LAST_LANE) begin
                    wvld_d = 1'b0;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end else if (busy_q) begin
                under_d = sat_inc16(under_q);
            end
        end

        cnt_d      = cnt_q + CNT_W'(app_rd_data_valid) - CNT_W'(pop);
        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(app_rd_data_valid);
        credit_sum = {1'b0, outst_d} + {1'b0, cnt_d};

        case (state_q)
            IDLE: begin
                if (start && init_calib_complete) begin
                    state_d  = REQ;
                    addr_d   = BASE_ADDR;
                    issued_d = '0;
                    outst_d  = '0;
                    under_d  = '0;
                end
            end
            REQ: begin
                if (accept) begin
                    addr_d   = addr_q + ADDR_W'(ADDR_STEP);
                    issued_d = issued_q + ISS_W'(1);
                    if (issued_q == LAST_WORD) begin
                        if (loop) begin
                            addr_d   = BASE_ADDR;
                            issued_d = '0;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                // A raised request is held until accepted; new requests need a free FIFO slot.
                if (en_q && !app_rdy) begin
                    en_d = 1'b1;
                end else begin
                    en_d = (state_d == REQ) && (credit_sum < CREDITS);
                end
            end
            DRAIN: begin
                en_d = 1'b0;
                if (outst_q == '0 && cnt_q == '0 && !wvld_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            issued_q <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lane_q   <= '0;
            wvld_q   <= 1'b0;
            sample_q <= '0;
            sval_q   <= 1'b0;
            under_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_q + PTR_W'(app_rd_data_valid);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            lane_q   <= lane_d;
            wvld_q   <= wvld_d;
            sample_q <= sample_d;
            sval_q   <= sval_d;
            under_q  <= under_d;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (app_rd_data_valid) begin
            mem_q[wr_ptr_q] <= app_rd_data;
        end
        word_q <= word_d;
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge ui_clk) disable iff (!sys_rst)
        !(app_rd_data_valid && cnt_q == CNT_W'(FIFO_DEPTH)));
`endif

    assign app_addr     = addr_q;
    assign app_cmd      = 3'b001;
    assign app_en       = en_q;
    assign sample       = sample_q;
    assign sample_valid = sval_q;
    assign busy         = busy_q;
    assign underrun_cnt = under_q;
endmodule
